// File: rtl/controller_pkg.sv
// Shared definitions for the emulated serial gamepad: FSM states, poll width
// and the bit position of each button in the parallel snapshot.
package controller_pkg;

    localparam int CTRL_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A is the MSB, so it is the first bit presented after the latch falls
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/pin_synchronizer.sv
// Multi-flop synchronizer for asynchronous pins, with single-cycle edge
// strobes derived from the synchronized value.
module pin_synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift the pin through the flop chain and remember the last settled value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/controller_responder.sv
// Device side of the serial gamepad protocol: snapshots the button bus while
// the host holds latch, then shifts the snapshot out active-low, MSB first,
// on each host clock rise. Flags completed polls, over-clocking and timeouts.
module controller_responder
    import controller_pkg::*;
#(
    parameter int BITS           = CTRL_BITS,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            latch_i,
    input  logic            ctrl_clk_i,
    input  logic [BITS-1:0] buttons_i,
    output logic            serial_no,
    output logic            poll_done_o,
    output logic            overrun_o,
    output logic            timeout_o,
    output logic [7:0]      polls_o
);

    localparam int CW = $clog2(BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic            latch_s, lfall, latch_rise_unused;
    logic            cclk_s, rise, cclk_fall_unused;
    logic [BITS-1:0] btn_s, btn_rise_unused, btn_fall_unused;

    state_t          state_q, state_d;
    logic [BITS-1:0] shift_q;
    logic [CW-1:0]   count_q;
    logic [TW-1:0]   timer_q;

    logic load, shift, clr_shift, count_inc, timer_inc, timer_clr;
    logic set_ovr, done_evt, timeout_evt, timer_expired;

    pin_synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .rst(rst), .d(latch_i),
        .q(latch_s), .rise(latch_rise_unused), .fall(lfall)
    );

    pin_synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_cclk (
        .clk(clk), .rst(rst), .d(ctrl_clk_i),
        .q(cclk_s), .rise(rise), .fall(cclk_fall_unused)
    );

    pin_synchronizer #(.WIDTH(BITS), .STAGES(SYNC_STAGES)) u_sync_btn (
        .clk(clk), .rst(rst), .d(buttons_i),
        .q(btn_s), .rise(btn_rise_unused), .fall(btn_fall_unused)
    );

    assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath controls; latch overrides any clock edge
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        shift       = 1'b0;
        clr_shift   = 1'b0;
        count_inc   = 1'b0;
        timer_inc   = 1'b0;
        timer_clr   = 1'b0;
        set_ovr     = 1'b0;
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        if (latch_s) begin
            state_d = LOAD;
            load    = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (lfall) state_d = SHIFT;
                end
                SHIFT: begin
                    if (rise) begin
                        shift     = 1'b1;
                        count_inc = 1'b1;
                        timer_clr = 1'b1;
                        if (count_q == CW'(BITS - 1)) begin
                            state_d  = DONE;
                            done_evt = 1'b1;
                        end
                    end else if (timer_expired) begin
                        state_d     = IDLE;
                        clr_shift   = 1'b1;
                        timer_clr   = 1'b1;
                        timeout_evt = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                DONE: begin
                    if (rise) begin
                        shift     = 1'b1;
                        set_ovr   = 1'b1;
                        timer_clr = 1'b1;
                    end else if (timer_expired) begin
                        state_d   = IDLE;
                        timer_clr = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                IDLE: begin
                    if (rise) shift = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shift register, counters and output flags
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            poll_done_o <= 1'b0;
            overrun_o   <= 1'b0;
            timeout_o   <= 1'b0;
            polls_o     <= '0;
        end else begin
            poll_done_o <= done_evt;
            timeout_o   <= timeout_evt;
            if (load) begin
                shift_q   <= btn_s;
                count_q   <= '0;
                timer_q   <= '0;
                overrun_o <= 1'b0;
            end else begin
                if (shift)          shift_q <= {shift_q[BITS-2:0], 1'b0};
                else if (clr_shift) shift_q <= '0;
                if (count_inc && count_q != CW'(BITS)) count_q <= count_q + CW'(1);
                if (timer_clr)      timer_q <= '0;
                else if (timer_inc) timer_q <= timer_q + TW'(1);
                if (set_ovr)  overrun_o <= 1'b1;
                if (done_evt) polls_o   <= polls_o + 8'd1;
            end
        end
    end

    assign serial_no = ~shift_q[BITS-1];

endmodule

// File: tb/tb_controller_responder.sv
// Directed bench for controller_responder acting as a host reader.
module tb_controller_responder;
    import controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       latch_i = 1'b0;
    logic       ctrl_clk_i = 1'b0;
    logic [7:0] buttons_i = 8'h00;
    logic       serial_no, poll_done_o, overrun_o, timeout_o;
    logic [7:0] polls_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int tmo_cnt  = 0;
    int done_base;
    logic [7:0] b80;

    controller_responder #(.BITS(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .latch_i(latch_i), .ctrl_clk_i(ctrl_clk_i),
        .buttons_i(buttons_i), .serial_no(serial_no), .poll_done_o(poll_done_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o), .polls_o(polls_o)
    );

    always #5 clk = ~clk;

    // Count single-cycle pulses away from the active edge
    always @(negedge clk) begin
        if (poll_done_o) done_cnt++;
        if (timeout_o)   tmo_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_clock();
        ctrl_clk_i = 1'b1;
        tick(4);
        ctrl_clk_i = 1'b0;
        tick(4);
    endtask

    task automatic do_latch(input logic [7:0] b);
        buttons_i = b;
        tick(4);
        latch_i = 1'b1;
        tick(4);
        latch_i = 1'b0;
        tick(4);
    endtask

    // Sample serial_no before each host clock; exp holds the bits in read order
    task automatic read_bits(input string tag, input int n, input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_bit%0d", tag, i), 32'(serial_no), 32'(exp[n-1-i]));
            host_clock();
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check_eq("rst_serial", 32'(serial_no), 32'd1);
        check_eq("rst_done", 32'(poll_done_o), 32'd0);
        check_eq("rst_ovr", 32'(overrun_o), 32'd0);
        check_eq("rst_tmo", 32'(timeout_o), 32'd0);
        check_eq("rst_polls", 32'(polls_o), 32'd0);
        rst = 1'b0;
        tick(2);

        // Normal poll: 1010_0001 reads 0,1,0,1,1,1,1,0
        done_base = done_cnt;
        do_latch(8'b1010_0001);
        read_bits("norm", 8, 16'b0101_1110);
        check_eq("norm_done", 32'(done_cnt - done_base), 32'd1);
        check_eq("norm_polls", 32'(polls_o), 32'd1);
        check_eq("norm_ovr", 32'(overrun_o), 32'd0);
        check_eq("norm_release", 32'(serial_no), 32'd1);

        // Overrun: ten clocks, bits 9 and 10 released
        do_latch(8'hFF);
        read_bits("ovr", 10, 16'b00_0000_0011);
        check_eq("ovr_flag", 32'(overrun_o), 32'd1);
        check_eq("ovr_polls", 32'(polls_o), 32'd2);
        latch_i = 1'b1;
        tick(4);
        check_eq("ovr_clear", 32'(overrun_o), 32'd0);
        latch_i = 1'b0;
        tick(4);
        read_bits("ovr_next", 8, 16'h0000);
        check_eq("ovr_next_polls", 32'(polls_o), 32'd3);

        // Relatch mid-poll with all buttons pressed
        done_base = done_cnt;
        do_latch(8'b1010_0001);
        read_bits("rel_a", 3, 16'b010);
        do_latch(8'hFF);
        read_bits("rel_b", 8, 16'h0000);
        check_eq("rel_done", 32'(done_cnt - done_base), 32'd1);
        check_eq("rel_polls", 32'(polls_o), 32'd4);

        // Clock pulses while latch is high are ignored
        b80 = '0;
        b80[BTN_A] = 1'b1;
        buttons_i = b80;
        tick(4);
        latch_i = 1'b1;
        tick(4);
        repeat (3) host_clock();
        latch_i = 1'b0;
        tick(4);
        read_bits("cdl", 8, 16'b0111_1111);
        check_eq("cdl_polls", 32'(polls_o), 32'd5);

        // Abandoned read: timeout pulse 16 idle cycles after the last rise
        do_latch(8'b1010_0001);
        read_bits("abn", 2, 16'b01);
        check_eq("abn_bit2", 32'(serial_no), 32'd0);
        tick(8);
        check_eq("abn_early_cnt", 32'(tmo_cnt), 32'd0);
        tick(2);
        check_eq("abn_pre", 32'(timeout_o), 32'd0);
        tick(1);
        check_eq("abn_pulse", 32'(timeout_o), 32'd1);
        check_eq("abn_serial", 32'(serial_no), 32'd1);
        tick(1);
        check_eq("abn_post", 32'(timeout_o), 32'd0);
        check_eq("abn_cnt", 32'(tmo_cnt), 32'd1);
        check_eq("abn_polls", 32'(polls_o), 32'd5);

        // Reset mid-poll
        do_latch(8'hFF);
        read_bits("mid", 5, 16'h0000);
        check_eq("mid_serial_pre", 32'(serial_no), 32'd0);
        rst = 1'b1;
        tick(1);
        check_eq("mid_serial", 32'(serial_no), 32'd1);
        check_eq("mid_done", 32'(poll_done_o), 32'd0);
        check_eq("mid_ovr", 32'(overrun_o), 32'd0);
        check_eq("mid_tmo", 32'(timeout_o), 32'd0);
        check_eq("mid_polls", 32'(polls_o), 32'd0);
        rst = 1'b0;
        tick(2);

        // 256 polls wrap the counter
        done_base = done_cnt;
        repeat (255) begin
            do_latch(8'h00);
            repeat (8) host_clock();
        end
        check_eq("wrap_255", 32'(polls_o), 32'd255);
        do_latch(8'h00);
        repeat (8) host_clock();
        check_eq("wrap_0", 32'(polls_o), 32'd0);
        check_eq("wrap_done", 32'(done_cnt - done_base), 32'd256);
        check_eq("silent_done_expiry", 32'(tmo_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
